// File: rtl/count_stream_checker_if.sv
// Bundle between a counter-stream source and its checker: sampled stream in,
// lock/error status out.
interface count_stream_checker_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) ();
  logic             en;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;
  logic [1:0]       state;

  modport master (
    output en, din, clr_err,
    input  locked, err_pulse, err_count, expected, state
  );

  modport slave (
    input  en, din, clr_err,
    output locked, err_pulse, err_count, expected, state
  );
endinterface

// File: rtl/count_stream_checker.sv
// Receive-side checker for an incrementing count stream: seeds from the first
// sample, locks after LOCK_CNT consecutive matches, and counts breaks while locked.
module count_stream_checker #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  count_stream_checker_if.slave  bus
);
  localparam int MC_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   expected_r, expected_s;
  logic [MC_W-1:0]    match_r, match_s;
  logic [ERR_W-1:0]   err_cnt_r, err_cnt_s;
  logic               err_pulse_r, locked_r;
  logic               err_s;
  logic [WIDTH-1:0]   din_next_s;

  assign din_next_s = bus.din + WIDTH'(STEP);

  // Next-state, next-expected and error detection.
  always_comb begin
    state_s    = state_r;
    expected_s = expected_r;
    match_s    = match_r;
    err_s      = 1'b0;
    case (state_r)
      ST_SEED: begin
        if (bus.en) begin
          expected_s = din_next_s;
          match_s    = {MC_W{1'b0}};
          state_s    = ST_ACQ;
        end else begin
          state_s    = ST_SEED;
        end
      end
      ST_ACQ: begin
        if (bus.en) begin
          expected_s = din_next_s;
          if (bus.din == expected_r) begin
            match_s = match_r + MC_W'(1);
            if (match_r == MC_W'(LOCK_CNT - 1)) begin
              state_s = ST_LOCKED;
            end else begin
              state_s = ST_ACQ;
            end
          end else begin
            match_s = {MC_W{1'b0}};
            state_s = ST_ACQ;
          end
        end else begin
          state_s = ST_ACQ;
        end
      end
      ST_LOCKED: begin
        if (bus.en && (bus.din == expected_r)) begin
          expected_s = expected_r + WIDTH'(STEP);
        end else if (bus.en) begin
          // Resync on the offending sample so a single glitch costs one error.
          err_s      = 1'b1;
          expected_s = din_next_s;
          match_s    = {MC_W{1'b0}};
          state_s    = ST_ACQ;
        end else begin
          state_s    = ST_LOCKED;
        end
      end
      default: begin
        state_s = ST_SEED;
      end
    endcase
  end

  // Saturating error total; a clear coinciding with an error keeps that error.
  always_comb begin
    err_cnt_s = err_cnt_r;
    if (bus.clr_err) begin
      err_cnt_s = err_s ? ERR_W'(1) : {ERR_W{1'b0}};
    end else if (err_s && (err_cnt_r != {ERR_W{1'b1}})) begin
      err_cnt_s = err_cnt_r + ERR_W'(1);
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_SEED;
      expected_r  <= {WIDTH{1'b0}};
      match_r     <= {MC_W{1'b0}};
      err_cnt_r   <= {ERR_W{1'b0}};
      err_pulse_r <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      expected_r  <= expected_s;
      match_r     <= match_s;
      err_cnt_r   <= err_cnt_s;
      err_pulse_r <= err_s;
      locked_r    <= (state_s == ST_LOCKED);
    end
  end

  assign bus.state     = state_r;
  assign bus.expected  = expected_r;
  assign bus.err_count = err_cnt_r;
  assign bus.err_pulse = err_pulse_r;
  assign bus.locked    = locked_r;
endmodule

// File: tb/tb_count_stream_checker.sv
// Directed bench for count_stream_checker: integer-level reference model checked
// every cycle, plus literal checkpoints from hand-worked sequences.
module tb_count_stream_checker;
  localparam int WIDTH = 8;
  localparam int ERR_W = 8;
  localparam int LOCK  = 4;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  bit   cmp_en;

  // Reference model state, plain integers
  int m_mode;     // 0 seed, 1 acquiring, 2 locked
  int m_exp;
  int m_run;
  int m_errs;
  int m_pulse;

  count_stream_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  count_stream_checker #(.WIDTH(WIDTH), .STEP(1), .LOCK_CNT(LOCK), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input int d, input bit c);
    bit bad;
    bad = 1'b0;
    if (r) begin
      m_mode = 0; m_exp = 0; m_run = 0; m_errs = 0; m_pulse = 0;
    end else begin
      if (e) begin
        if (m_mode == 0) begin
          m_run = 0;
          m_mode = 1;
        end else if (m_mode == 1) begin
          m_run = (d == m_exp) ? m_run + 1 : 0;
          if (m_run >= LOCK) m_mode = 2;
        end else if (d != m_exp) begin
          bad = 1'b1;
          m_run = 0;
          m_mode = 1;
        end
        m_exp = (m_mode == 2 && !bad) ? (m_exp + 1) % 256 : (d + 1) % 256;
      end
      m_pulse = bad;
      if (c) m_errs = bad ? 1 : 0;
      else if (bad && m_errs < 255) m_errs = m_errs + 1;
    end
  endtask

  task automatic apply(input bit r, input bit e, input int d, input bit c);
    @(negedge clk);
    rst = r; bus.en = e; bus.din = d[7:0]; bus.clr_err = c;
    @(posedge clk);
    model_edge(r, e, d, c);
    cmp_en = 1'b1;
    #1;
  endtask

  task automatic run(input int start, input int n);
    for (int k = 0; k < n; k++) apply(1'b0, 1'b1, (start + k) % 256, 1'b0);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("state",     32'(bus.state),     32'(m_mode));
      check("locked",    32'(bus.locked),    (m_mode == 2) ? 32'd1 : 32'd0);
      check("expected",  32'(bus.expected), 32'(m_exp));
      check("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
      check("err_count", 32'(bus.err_count), 32'(m_errs));
    end
  end

  initial begin
    int cur;
    int bad;
    vectors = 0; miscompares = 0; cmp_en = 1'b0;
    rst = 1'b1; bus.en = 1'b0; bus.din = 8'h00; bus.clr_err = 1'b0;

    // 1: reset then 0..4 locks on the fifth sample
    apply(1'b1, 1'b0, 0, 1'b0);
    apply(1'b1, 1'b0, 0, 1'b0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_expected", 32'(bus.expected), 32'd0);
    run(0, 4);
    check("pre_lock", 32'(bus.locked), 32'd0);
    run(4, 1);
    check("lock1", 32'(bus.locked), 32'd1);
    check("lock1_err", 32'(bus.err_count), 32'd0);

    // 3: locked at 10, then 15 breaks it, 16..19 relocks
    run(5, 6);
    apply(1'b0, 1'b1, 15, 1'b0);
    check("brk_pulse", 32'(bus.err_pulse), 32'd1);
    check("brk_count", 32'(bus.err_count), 32'd1);
    check("brk_state", 32'(bus.state), 32'd1);
    check("brk_exp", 32'(bus.expected), 32'd16);
    run(16, 1);
    check("brk_pulse_end", 32'(bus.err_pulse), 32'd0);
    run(17, 3);
    check("relock", 32'(bus.locked), 32'd1);

    // 2: wrap FF->00 while locked is not an error
    apply(1'b1, 1'b0, 0, 1'b0);
    run(8'hF9, 10);
    check("wrap_locked", 32'(bus.locked), 32'd1);
    check("wrap_err", 32'(bus.err_count), 32'd0);
    check("wrap_exp", 32'(bus.expected), 32'h03);

    // 4: en low with garbage holds everything
    apply(1'b0, 1'b0, 8'h77, 1'b0);
    apply(1'b0, 1'b0, 8'hA5, 1'b0);
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    check("hold_exp", 32'(bus.expected), 32'h03);
    check("hold_state", 32'(bus.state), 32'd2);
    run(3, 2);
    check("hold_err", 32'(bus.err_count), 32'd0);

    // 5: 300 errors saturate the counter, pulses continue
    cur = 5;
    for (int i = 0; i < 300; i++) begin
      bad = (cur + 8'h40) % 256;
      apply(1'b0, 1'b1, bad, 1'b0);
      run(bad + 1, LOCK);
      cur = (bad + 1 + LOCK) % 256;
    end
    check("sat_count", 32'(bus.err_count), 32'd255);
    apply(1'b0, 1'b1, (cur + 8'h40) % 256, 1'b0);
    check("sat_pulse", 32'(bus.err_pulse), 32'd1);
    check("sat_hold", 32'(bus.err_count), 32'd255);
    cur = ((cur + 8'h40) % 256 + 1) % 256;
    run(cur, LOCK);
    cur = (cur + LOCK) % 256;
    apply(1'b0, 1'b1, (cur + 3) % 256, 1'b1);
    check("clr_with_err", 32'(bus.err_count), 32'd1);
    apply(1'b0, 1'b0, 0, 1'b1);
    check("clr_alone", 32'(bus.err_count), 32'd0);

    // 6: one more error, relock, then reset mid-stream
    cur = ((cur + 3) % 256 + 1) % 256;
    run(cur, LOCK);
    apply(1'b0, 1'b1, (cur + LOCK + 9) % 256, 1'b0);
    cur = (cur + LOCK + 10) % 256;
    run(cur, LOCK);
    check("pre_rst_locked", 32'(bus.locked), 32'd1);
    apply(1'b1, 1'b1, 8'h55, 1'b0);
    check("rst_mid_state", 32'(bus.state), 32'd0);
    check("rst_mid_locked", 32'(bus.locked), 32'd0);
    check("rst_mid_err", 32'(bus.err_count), 32'd0);
    run(8'h30, 4);
    check("restart_unlocked", 32'(bus.locked), 32'd0);
    run(8'h34, 1);
    check("restart_locked", 32'(bus.locked), 32'd1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
